// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup on the fetch PC; training from the execution stage on the clock edge.
module branch_target_buffer #(
    parameter int         ENTRIES      = 16,
    parameter int         INDEX_BITS   = 4,
    parameter logic [1:0] COUNTER_INIT = 2'b10
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] PC,
    output logic        PREDICT_STATUS,
    output logic [31:0] PREDICT_TARGET,
    input  logic        UPDATE_VALID,
    input  logic        STALL_EXECUTION_STAGE,
    input  logic [31:0] UPDATE_PC,
    input  logic [31:0] UPDATE_TARGET,
    input  logic        UPDATE_TAKEN,
    output logic [15:0] HIT_COUNT
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic                  valid_q   [ENTRIES];
    logic [1:0]            counter_q [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q     [ENTRIES];
    logic [31:0]           target_q  [ENTRIES];

    logic [INDEX_BITS-1:0] lookup_index;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic [INDEX_BITS-1:0] update_index;
    logic [TAG_BITS-1:0]   update_tag;
    logic                  lookup_hit;
    logic                  update_hit;
    logic                  write_enable;

    assign lookup_index = PC[INDEX_BITS+1:2];
    assign lookup_tag   = PC[31:INDEX_BITS+2];
    assign update_index = UPDATE_PC[INDEX_BITS+1:2];
    assign update_tag   = UPDATE_PC[31:INDEX_BITS+2];

    // RST_N gating keeps outputs quiet and blocks writes while reset is held
    assign lookup_hit     = RST_N && valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
    assign PREDICT_STATUS = lookup_hit && counter_q[lookup_index][1];
    assign PREDICT_TARGET = PREDICT_STATUS ? target_q[lookup_index] : 32'h0;

    assign update_hit   = valid_q[update_index] && (tag_q[update_index] == update_tag);
    assign write_enable = RST_N && UPDATE_VALID && !STALL_EXECUTION_STAGE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                counter_q[i] <= 2'b01;
            end
        end else if (write_enable) begin
            if (update_hit) begin
                if (UPDATE_TAKEN) begin
                    if (counter_q[update_index] != 2'b11)
                        counter_q[update_index] <= counter_q[update_index] + 2'd1;
                end else begin
                    if (counter_q[update_index] != 2'b00)
                        counter_q[update_index] <= counter_q[update_index] - 2'd1;
                end
            end else if (UPDATE_TAKEN) begin
                valid_q[update_index]   <= 1'b1;
                counter_q[update_index] <= COUNTER_INIT;
            end
        end
    end

    // Tags and targets carry no reset; valid bits make stale contents harmless
    always_ff @(posedge CLK) begin
        if (write_enable && UPDATE_TAKEN) begin
            target_q[update_index] <= UPDATE_TARGET;
            if (!update_hit)
                tag_q[update_index] <= update_tag;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            HIT_COUNT <= 16'h0;
        else if (PREDICT_STATUS && !STALL_EXECUTION_STAGE)
            HIT_COUNT <= HIT_COUNT + 16'd1;
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
// Inputs change on the falling edge; outputs are sampled 1 ns after a change or edge.
module tb_branch_target_buffer;

    localparam logic [31:0] IDLE_PC = 32'h0000_1000;

    logic        CLK;
    logic        RST_N;
    logic [31:0] PC;
    logic        PREDICT_STATUS;
    logic [31:0] PREDICT_TARGET;
    logic        UPDATE_VALID;
    logic        STALL_EXECUTION_STAGE;
    logic [31:0] UPDATE_PC;
    logic [31:0] UPDATE_TARGET;
    logic        UPDATE_TAKEN;
    logic [15:0] HIT_COUNT;

    int          tests;
    int          fails;
    logic [15:0] exp_hits;

    branch_target_buffer dut (
        .CLK                  (CLK),
        .RST_N                (RST_N),
        .PC                   (PC),
        .PREDICT_STATUS       (PREDICT_STATUS),
        .PREDICT_TARGET       (PREDICT_TARGET),
        .UPDATE_VALID         (UPDATE_VALID),
        .STALL_EXECUTION_STAGE(STALL_EXECUTION_STAGE),
        .UPDATE_PC            (UPDATE_PC),
        .UPDATE_TARGET        (UPDATE_TARGET),
        .UPDATE_TAKEN         (UPDATE_TAKEN),
        .HIT_COUNT            (HIT_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic set_pc(input logic [31:0] pc);
        @(negedge CLK);
        PC = pc;
        #1;
    endtask

    task automatic park();
        PC = IDLE_PC;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_update(input logic [31:0] upc, input logic [31:0] utgt, input logic taken);
        @(negedge CLK);
        PC            = IDLE_PC;
        UPDATE_VALID  = 1'b1;
        UPDATE_PC     = upc;
        UPDATE_TARGET = utgt;
        UPDATE_TAKEN  = taken;
        @(posedge CLK);
        #1;
        UPDATE_VALID  = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        PC    = 32'h0000_0040;
        #12;
        tests++;
        if (PREDICT_STATUS !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: got %b expected 0", PREDICT_STATUS);
        end
        tests++;
        if (PREDICT_TARGET !== 32'h0) begin
            fails++;
            $display("FAIL reset_target: got %h expected 00000000", PREDICT_TARGET);
        end
        tests++;
        if (HIT_COUNT !== 16'h0) begin
            fails++;
            $display("FAIL reset_hit_count: got %h expected 0000", HIT_COUNT);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        park();
    endtask

    task automatic test_allocate();
        do_update(32'h40, 32'h100, 1'b1);
        set_pc(32'h40);
        tests++;
        if (PREDICT_STATUS !== 1'b1 || PREDICT_TARGET !== 32'h100) begin
            fails++;
            $display("FAIL alloc_lookup: got %b/%h expected 1/00000100", PREDICT_STATUS, PREDICT_TARGET);
        end
        tick();
        exp_hits++;
        tests++;
        if (HIT_COUNT !== exp_hits) begin
            fails++;
            $display("FAIL alloc_hit_count: got %h expected %h", HIT_COUNT, exp_hits);
        end
        park();
    endtask

    task automatic test_counter();
        // 10 -> 01 -> 00
        do_update(32'h40, 32'h100, 1'b0);
        set_pc(32'h40);
        tests++;
        if (PREDICT_STATUS !== 1'b0 || PREDICT_TARGET !== 32'h0) begin
            fails++;
            $display("FAIL ctr_01: got %b/%h expected 0/00000000", PREDICT_STATUS, PREDICT_TARGET);
        end
        park();
        do_update(32'h40, 32'h100, 1'b0);
        // 00 -> 01 stays not-taken
        do_update(32'h40, 32'h104, 1'b1);
        set_pc(32'h40);
        tests++;
        if (PREDICT_STATUS !== 1'b0) begin
            fails++;
            $display("FAIL ctr_00_to_01: got %b expected 0", PREDICT_STATUS);
        end
        park();
        do_update(32'h40, 32'h108, 1'b1);
        do_update(32'h40, 32'h10C, 1'b1);
        set_pc(32'h40);
        tests++;
        if (PREDICT_STATUS !== 1'b1 || PREDICT_TARGET !== 32'h10C) begin
            fails++;
            $display("FAIL ctr_11: got %b/%h expected 1/0000010c", PREDICT_STATUS, PREDICT_TARGET);
        end
        park();
        // Fourth taken saturates at 11: one not-taken keeps taken, second drops it
        do_update(32'h40, 32'h110, 1'b1);
        do_update(32'h40, 32'h999, 1'b0);
        set_pc(32'h40);
        tests++;
        if (PREDICT_STATUS !== 1'b1 || PREDICT_TARGET !== 32'h110) begin
            fails++;
            $display("FAIL ctr_saturate: got %b/%h expected 1/00000110", PREDICT_STATUS, PREDICT_TARGET);
        end
        park();
        do_update(32'h40, 32'h999, 1'b0);
        set_pc(32'h40);
        tests++;
        if (PREDICT_STATUS !== 1'b0) begin
            fails++;
            $display("FAIL ctr_dec_from_10: got %b expected 0", PREDICT_STATUS);
        end
        park();
    endtask

    task automatic test_miss_not_taken();
        do_update(32'h44, 32'h300, 1'b0);
        set_pc(32'h44);
        tests++;
        if (PREDICT_STATUS !== 1'b0) begin
            fails++;
            $display("FAIL miss_not_taken: got %b expected 0", PREDICT_STATUS);
        end
        park();
    endtask

    task automatic test_alias();
        do_update(32'h40, 32'h100, 1'b1);
        set_pc(32'h40);
        tests++;
        if (PREDICT_STATUS !== 1'b1 || PREDICT_TARGET !== 32'h100) begin
            fails++;
            $display("FAIL alias_before: got %b/%h expected 1/00000100", PREDICT_STATUS, PREDICT_TARGET);
        end
        // Same-cycle lookup and update of one index returns pre-update contents
        UPDATE_VALID  = 1'b1;
        UPDATE_PC     = 32'h80;
        UPDATE_TARGET = 32'h200;
        UPDATE_TAKEN  = 1'b1;
        #1;
        tests++;
        if (PREDICT_STATUS !== 1'b1 || PREDICT_TARGET !== 32'h100) begin
            fails++;
            $display("FAIL no_bypass: got %b/%h expected 1/00000100", PREDICT_STATUS, PREDICT_TARGET);
        end
        tick();
        exp_hits++;
        UPDATE_VALID = 1'b0;
        tests++;
        if (PREDICT_STATUS !== 1'b0) begin
            fails++;
            $display("FAIL alias_evicted: got %b expected 0", PREDICT_STATUS);
        end
        tests++;
        if (HIT_COUNT !== exp_hits) begin
            fails++;
            $display("FAIL alias_hit_count: got %h expected %h", HIT_COUNT, exp_hits);
        end
        park();
        set_pc(32'h80);
        tests++;
        if (PREDICT_STATUS !== 1'b1 || PREDICT_TARGET !== 32'h200) begin
            fails++;
            $display("FAIL alias_new: got %b/%h expected 1/00000200", PREDICT_STATUS, PREDICT_TARGET);
        end
        park();
    endtask

    task automatic test_stall();
        @(negedge CLK);
        PC                    = 32'h80;
        STALL_EXECUTION_STAGE = 1'b1;
        UPDATE_VALID          = 1'b1;
        UPDATE_PC             = 32'hC0;
        UPDATE_TARGET         = 32'h400;
        UPDATE_TAKEN          = 1'b1;
        tick();
        tick();
        tests++;
        if (HIT_COUNT !== exp_hits) begin
            fails++;
            $display("FAIL stall_hit_count: got %h expected %h", HIT_COUNT, exp_hits);
        end
        @(negedge CLK);
        UPDATE_VALID          = 1'b0;
        STALL_EXECUTION_STAGE = 1'b0;
        PC                    = 32'hC0;
        #1;
        tests++;
        if (PREDICT_STATUS !== 1'b0) begin
            fails++;
            $display("FAIL stall_no_alloc: got %b expected 0", PREDICT_STATUS);
        end
        PC = 32'h80;
        #1;
        tests++;
        if (PREDICT_STATUS !== 1'b1 || PREDICT_TARGET !== 32'h200) begin
            fails++;
            $display("FAIL stall_kept_entry: got %b/%h expected 1/00000200", PREDICT_STATUS, PREDICT_TARGET);
        end
        park();
    endtask

    task automatic test_reset_mid();
        set_pc(32'h80);
        #2;
        RST_N = 1'b0;
        #1;
        tests++;
        if (PREDICT_STATUS !== 1'b0 || PREDICT_TARGET !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_out: got %b/%h expected 0/00000000", PREDICT_STATUS, PREDICT_TARGET);
        end
        tests++;
        if (HIT_COUNT !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid_count: got %h expected 0000", HIT_COUNT);
        end
        exp_hits = 16'h0;
        // Update held through reset must be ignored, then accepted on the first edge after release
        UPDATE_VALID  = 1'b1;
        UPDATE_PC     = 32'h44;
        UPDATE_TARGET = 32'h500;
        UPDATE_TAKEN  = 1'b1;
        tick();
        @(negedge CLK);
        UPDATE_PC     = 32'h48;
        UPDATE_TARGET = 32'h600;
        RST_N         = 1'b1;
        tick();
        UPDATE_VALID  = 1'b0;
        PC            = 32'h44;
        #1;
        tests++;
        if (PREDICT_STATUS !== 1'b0) begin
            fails++;
            $display("FAIL reset_update_ignored: got %b expected 0", PREDICT_STATUS);
        end
        PC = 32'h80;
        #1;
        tests++;
        if (PREDICT_STATUS !== 1'b0) begin
            fails++;
            $display("FAIL reset_cleared_entry: got %b expected 0", PREDICT_STATUS);
        end
        PC = 32'h48;
        #1;
        tests++;
        if (PREDICT_STATUS !== 1'b1 || PREDICT_TARGET !== 32'h600) begin
            fails++;
            $display("FAIL first_update_after_reset: got %b/%h expected 1/00000600", PREDICT_STATUS, PREDICT_TARGET);
        end
        park();
        do_update(32'h80, 32'h700, 1'b1);
        set_pc(32'h80);
        tests++;
        if (PREDICT_STATUS !== 1'b1 || PREDICT_TARGET !== 32'h700) begin
            fails++;
            $display("FAIL retrain: got %b/%h expected 1/00000700", PREDICT_STATUS, PREDICT_TARGET);
        end
        park();
    endtask

    task automatic test_hit_wrap();
        set_pc(32'h80);
        while (exp_hits != 16'hFFFF) begin
            tick();
            exp_hits++;
        end
        tests++;
        if (HIT_COUNT !== 16'hFFFF) begin
            fails++;
            $display("FAIL hit_count_max: got %h expected ffff", HIT_COUNT);
        end
        tick();
        exp_hits++;
        tests++;
        if (HIT_COUNT !== 16'h0000) begin
            fails++;
            $display("FAIL hit_count_wrap: got %h expected 0000", HIT_COUNT);
        end
        park();
    endtask

    initial begin
        tests                 = 0;
        fails                 = 0;
        exp_hits              = 16'h0;
        PC                    = IDLE_PC;
        UPDATE_VALID          = 1'b0;
        STALL_EXECUTION_STAGE = 1'b0;
        UPDATE_PC             = 32'h0;
        UPDATE_TARGET         = 32'h0;
        UPDATE_TAKEN          = 1'b0;
        test_reset();
        test_allocate();
        test_counter();
        test_miss_not_taken();
        test_alias();
        test_stall();
        test_reset_mid();
        test_hit_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- Answers the program-counter stage's prediction query: PREDICT_STATUS and PREDICT_TARGET drive its predict-select mux.
- Trained by branch/jump resolution from the execution stage.
- Lookup is combinational on the current PC; training writes the table on the clock edge.

Parameters:
- ENTRIES, 16, number of table entries; power of two, at least 2.
- INDEX_BITS, 4, log2(ENTRIES); must match ENTRIES.
- COUNTER_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- CLK  input  1  clock; all table writes on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- PC  input  32  current fetch PC (program-counter register).
- PREDICT_STATUS  output  1  high = predict taken, use PREDICT_TARGET.
- PREDICT_TARGET  output  32  predicted next PC; 0 when PREDICT_STATUS low.
- UPDATE_VALID  input  1  execution stage holds a resolved branch, JAL or JALR.
- STALL_EXECUTION_STAGE  input  1  high = execution stalled; suppresses the update.
- UPDATE_PC  input  32  PC of the resolved instruction.
- UPDATE_TARGET  input  32  resolved target address (base + immediate).
- UPDATE_TAKEN  input  1  instruction actually redirected control flow.
- HIT_COUNT  output  16  count of lookups that returned PREDICT_STATUS high on cycles with no stall.

Behaviour:
- Address fields:
  - index = PC[INDEX_BITS+1:2].
  - tag = PC[31:INDEX_BITS+2].
  - PC[1:0] is ignored.
- Entry contents: valid bit, tag, 32-bit target, 2-bit counter.
- Lookup (combinational):
  - hit = valid[index] & (tag[index] == PC tag).
  - PREDICT_STATUS = hit & counter[index][1].
  - PREDICT_TARGET = target[index] when PREDICT_STATUS is high, else 32'h0.
- Update: write enable we = UPDATE_VALID & ~STALL_EXECUTION_STAGE, applied at the rising CLK edge, indexed and tagged by UPDATE_PC.
  - Hit, taken: counter saturating +1 (max 2'b11); target <= UPDATE_TARGET.
  - Hit, not taken: counter saturating -1 (min 2'b00); target and valid unchanged.
  - Miss, taken: allocate and overwrite any previous occupant. valid <= 1, tag <= UPDATE_PC tag, target <= UPDATE_TARGET, counter <= COUNTER_INIT.
  - Miss, not taken: no state change.
- Latency: a lookup in the cycle after the update edge sees the new entry. The table is write-then-read across the edge only.
- Same index looked up and updated in one cycle: the lookup returns pre-update contents (no bypass).
- Aliasing: two PCs with equal index and different tags evict each other. Only the most recent taken allocation survives.
- HIT_COUNT:
  - Increments by 1 on each rising edge where PREDICT_STATUS is high and STALL_EXECUTION_STAGE is low.
  - Wraps 16'hFFFF -> 0.
- Reset (RST_N low, asynchronous, any cycle including mid-update):
  - All valid bits <= 0; all counters <= 2'b01; HIT_COUNT <= 0.
  - Targets and tags are not reset.
  - While RST_N is low: PREDICT_STATUS = 0, PREDICT_TARGET = 0, and updates are ignored.
  - First update is accepted on the first rising edge with RST_N high.
- Unknown/X on PC must not propagate into valid bits or counters of untouched entries.

Test Plan:
- Reset, then PC=32'h0000_0040 -> PREDICT_STATUS=0, PREDICT_TARGET=0, HIT_COUNT=0.
- Update UPDATE_PC=32'h40, UPDATE_TARGET=32'h100, UPDATE_TAKEN=1; next cycle PC=32'h40 -> PREDICT_STATUS=1, PREDICT_TARGET=32'h100. HIT_COUNT increments to 1 on that edge.
- Two not-taken updates at 32'h40 -> counter 10->01->00; PREDICT_STATUS=0. Three taken updates -> 01, 10, 11; PREDICT_STATUS=1. A fourth taken update stays at 11.
- Alias: allocate 32'h40 (target 32'h100), then taken update at 32'h80 (same index for ENTRIES=16, different tag), target 32'h200. PC=32'h40 -> status 0; PC=32'h80 -> target 32'h200.
- STALL_EXECUTION_STAGE=1 with UPDATE_VALID=1, taken at 32'hC0 -> no allocation; PC=32'hC0 -> status 0; HIT_COUNT frozen during the stall.
- RST_N pulsed low mid-cycle after entries are trained -> outputs drop to 0 immediately. After release, the previously trained PC misses until retrained.
